// File: rtl/mem_pkg.sv
// Types and helpers shared by the memory-access stage and the load extender.
package mem_pkg;
   localparam int BYTE_LANES = 8;

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10,
      SIZE_D = 2'b11
   } size_e;

   typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, FAULT} state_e;

   function automatic logic is_misaligned(input size_e size, input logic [2:0] off);
      case (size)
         SIZE_H:  return off[0];
         SIZE_W:  return off[1:0] != 2'b00;
         SIZE_D:  return off != 3'b000;
         default: return 1'b0;
      endcase
   endfunction

   // Naturally aligned accesses never shift bits out of the 8-lane mask.
   function automatic logic [BYTE_LANES-1:0] byte_enable(input size_e size, input logic [2:0] off);
      logic [BYTE_LANES-1:0] mask;
      case (size)
         SIZE_B:  mask = 8'h01;
         SIZE_H:  mask = 8'h03;
         SIZE_W:  mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask << off;
   endfunction
endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Moves the addressed bytes of an aligned word to the LSBs and sign/zero extends them.
module load_extend
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic [DATA_WIDTH-1:0] word,
   input  logic [2:0]            offset,
   input  size_e                 size,
   input  logic                  zero_ext,
   output logic [DATA_WIDTH-1:0] result
);
   logic [DATA_WIDTH-1:0] lane;

   assign lane = word >> {offset, 3'b000};

   always_comb begin
      // NOTE: assign a default before the case so every path drives result and no latch is inferred.
      result = lane;
      case (size)
         SIZE_B:  result = {{(DATA_WIDTH-8){~zero_ext & lane[7]}}, lane[7:0]};
         SIZE_H:  result = {{(DATA_WIDTH-16){~zero_ext & lane[15]}}, lane[15:0]};
         SIZE_W:  result = {{(DATA_WIDTH-32){~zero_ext & lane[31]}}, lane[31:0]};
         default: result = lane;
      endcase
   end
endmodule

// File: rtl/mem_access_unit.sv
// Multicycle memory-access stage: latches one request, drives the unified memory port,
// and returns extended load data or store byte-enables with a one-cycle done pulse.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk_i,
   input  logic                  arst_n_i,
   input  logic                  start_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [1:0]            size_i,
   input  logic                  unsigned_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  misaligned_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic [7:0]            mem_be_o,
   input  logic                  mem_ready_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
   state_e                state_q, state_d;
   size_e                 size_q;
   logic                  zero_ext_q;
   logic [2:0]            offset_q;
   logic                  accept;
   logic                  req_d, busy_d, done_d, fault_d;
   logic [DATA_WIDTH-1:0] load_data;

   assign accept = (state_q == IDLE) && start_i;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (!arst_n_i) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = is_misaligned(size_e'(size_i), addr_i[2:0]) ? FAULT : REQ;
         REQ:     if (mem_ready_i) state_d = mem_we_o ? DONE : RESP;
         RESP:    if (mem_rvalid_i) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they change with the state.
   always_comb begin
      req_d   = (state_d == REQ);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE) || (state_d == FAULT);
      fault_d = (state_d == FAULT);
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         mem_req_o    <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         misaligned_o <= 1'b0;
      end else begin
         mem_req_o    <= req_d;
         busy_o       <= busy_d;
         done_o       <= done_d;
         misaligned_o <= fault_d;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         size_q      <= SIZE_B;
         zero_ext_q  <= 1'b0;
         offset_q    <= 3'b000;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_be_o    <= '0;
         rdata_o     <= '0;
      end else begin
         if (accept) begin
            size_q      <= size_e'(size_i);
            zero_ext_q  <= unsigned_i;
            offset_q    <= addr_i[2:0];
            mem_we_o    <= we_i;
            mem_addr_o  <= {addr_i[ADDR_WIDTH-1:3], 3'b000};
            mem_wdata_o <= wdata_i << {addr_i[2:0], 3'b000};
            mem_be_o    <= byte_enable(size_e'(size_i), addr_i[2:0]);
         end
         if ((state_q == RESP) && mem_rvalid_i) rdata_o <= load_data;
      end
   end

   load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
      .word     (mem_rdata_i),
      .offset   (offset_q),
      .size     (size_q),
      .zero_ext (zero_ext_q),
      .result   (load_data)
   );
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequential memory-access stage directly downstream of the memory-address 2-to-1 mux in the multicycle core.
- Latches the selected address, which is either PCNext or the calculated result, plus access attributes on a start pulse from the control FSM.
- Runs a valid/ready request plus read-response handshake to the unified memory port.
- Returns aligned, sign/zero-extended load data, or store byte-enables, with a one-cycle completion pulse.

Parameters:
- ADDR_WIDTH, 64, width of address in and out.
- DATA_WIDTH, 64, memory word width. Fixed at 64; offset logic assumes 8 byte lanes.

Ports:
- clk_i  in  1  core clock.
- arst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle request from control FSM; ignored unless in IDLE.
- we_i  in  1  1 = store, 0 = load/fetch.
- addr_i  in  ADDR_WIDTH  byte address from the address mux output.
- size_i  in  2  00 byte, 01 half, 10 word, 11 dword.
- unsigned_i  in  1  1 = zero-extend load, 0 = sign-extend.
- wdata_i  in  DATA_WIDTH  store data, LSB-justified.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- misaligned_o  out  1  valid with done_o; access not naturally aligned.
- rdata_o  out  DATA_WIDTH  extended load result; held until next done_o.
- mem_req_o  out  1  request valid.
- mem_we_o  out  1  request is a write.
- mem_addr_o  out  ADDR_WIDTH  addr with [2:0] forced to 0.
- mem_wdata_o  out  DATA_WIDTH  store data shifted to lane.
- mem_be_o  out  8  byte enables.
- mem_ready_i  in  1  memory accepts request this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  DATA_WIDTH  64-bit aligned read word.

Behaviour:
- Reset (async, arst_n_i=0): state IDLE. All outputs are 0, including rdata_o.
- Only one clock, clk_i. All outputs are registered.
- IDLE, with start_i=1:
  - Latch we, addr, size, unsigned, wdata.
  - Misaligned = (size=01 & a[0]) | (size=10 & a[1:0]≠0) | (size=11 & a[2:0]≠0).
  - If misaligned, go to FAULT; else go to REQ.
- REQ:
  - mem_req_o=1. mem_addr_o, mem_we_o, mem_wdata_o and mem_be_o stay stable until the acceptance cycle.
  - mem_be_o = (size mask 0x01/0x03/0x0F/0xFF) << a[2:0].
  - mem_wdata_o = wdata << (8*a[2:0]).
  - On mem_ready_i=1: store goes to DONE; load goes to RESP.
  - mem_req_o drops the cycle after acceptance.
- RESP:
  - Wait for mem_rvalid_i. No timeout.
  - On rvalid, rdata_o = extend(mem_rdata_i >> 8*a[2:0], size, unsigned). Go to DONE.
  - Dword loads ignore unsigned_i.
- DONE: done_o=1 for exactly one cycle, misaligned_o=0, then IDLE.
- FAULT:
  - done_o=1 and misaligned_o=1 for one cycle, then IDLE.
  - No memory request is issued. rdata_o is unchanged.
- Latency (zero-wait memory, ready in the first REQ cycle, rvalid in the cycle after acceptance):
  - Store: start at cycle 0, done at cycle 2.
  - Load: start at cycle 0, done at cycle 3.
  - Misaligned: start at cycle 0, done at cycle 1.
- Boundaries:
  - start_i while busy: ignored; no queuing.
  - mem_rvalid_i outside RESP: ignored.
  - mem_ready_i outside REQ: ignored.
  - Reset mid-transaction: immediate IDLE, mem_req_o deasserted, any pending response discarded.
  - start_i is accepted in the same cycle IDLE is re-entered after DONE, i.e. the cycle done_o is high counts as DONE, not IDLE. Back-to-back accesses therefore have one idle cycle minimum.
- Address arithmetic: no wrap handling needed. mem_addr_o is a masked copy of the latched address.

Decomposition:
- Shared package mem_pkg holds:
  - typedef enum for size encoding (SIZE_B/H/W/D).
  - typedef enum for FSM state (IDLE, REQ, RESP, DONE, FAULT).
  - Constant BYTE_LANES=8.
- Sub-module load_extend: combinational shift-by-offset plus sign/zero extension. It is reused later by the pipeline's load unit.

Test Plan:
- Load byte, signed: addr=0x1003, size=00, unsigned=0, rdata word=0x0000_0000_8000_0000.
  - mem_addr_o=0x1000, be=0x08, mem_we_o=0.
  - rdata_o=0xFFFF_FFFF_FFFF_FF80; done at cycle 3.
- Store half: addr=0x2006, size=01, wdata=0xABCD.
  - be=0xC0, mem_wdata_o=0xABCD_0000_0000_0000.
  - done at cycle 2, no rvalid needed.
- Misaligned word: addr=0x3002, size=10.
  - mem_req_o never asserts.
  - done_o=misaligned_o=1 at cycle 1.
- Backpressure: mem_ready_i held 0 for 5 cycles.
  - mem_req_o and all mem_* signals stable for 6 cycles.
  - done exactly once after acceptance plus response; start_i pulses during busy are ignored.
- Unsigned word load: addr=0x4004, rdata=0xF234_5678_0000_0000.
  - rdata_o=0x0000_0000_F234_5678.
  - Repeat with unsigned=0: rdata_o=0xFFFF_FFFF_F234_5678.
- Reset in RESP: assert arst_n_i=0 mid-load.
  - All outputs 0 asynchronously.
  - A late rvalid after reset release is ignored; the next start proceeds normally.
